// File: rtl/ol_walker.sv
// Object-list walker: fetches list words from VRAM, follows links and emits one
// parser job per strip or per array primitive, waiting for poly_drawn between jobs.
module ol_walker #(
  parameter int MAX_ENTRIES = 4096
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [23:0] ol_base_i,
  input  logic [23:0] param_base_i,
  output logic        vram_rd_o,
  output logic [23:0] vram_addr_o,
  input  logic [31:0] vram_din_i,
  input  logic        vram_ack_i,
  output logic [31:0] opb_word_o,
  output logic [23:0] poly_addr_o,
  output logic        render_poly_o,
  input  logic        poly_drawn_i,
  output logic        busy_o,
  output logic        list_done_o,
  output logic        list_err_o
);

  localparam int CW = $clog2(MAX_ENTRIES + 2);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [23:0]   cur_q, cur_d;
  logic [23:0]   pbase_q, pbase_d;
  logic [23:0]   paddr_q, paddr_d;
  logic [23:0]   stride_q, stride_d;
  logic [31:0]   word_q, word_d;
  logic [3:0]    rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic        is_quad;
  logic [23:0] verts;
  logic [23:0] hdr_words;
  logic [23:0] stride_words;
  logic [23:0] entry_addr;

  // Array stride: header words plus one (3 + skip)-word block per vertex.
  assign is_quad      = (word_q[31:29] == 3'b101);
  assign verts        = is_quad ? 24'd4 : 24'd3;
  assign hdr_words    = word_q[24] ? 24'd5 : 24'd3;
  assign stride_words = hdr_words + verts * (24'd3 + {21'd0, word_q[23:21]});
  assign entry_addr   = pbase_q + {1'b0, word_q[20:0], 2'b00};

  assign vram_addr_o = cur_q;
  assign opb_word_o  = word_q;
  assign poly_addr_o = paddr_q;
  assign list_err_o  = err_q;

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    pbase_d       = pbase_q;
    paddr_d       = paddr_q;
    stride_d      = stride_q;
    word_d        = word_q;
    rem_d         = rem_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    vram_rd_o     = 1'b0;
    render_poly_o = 1'b0;
    busy_o        = 1'b0;
    list_done_o   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pbase_d = param_base_i;
          cur_d   = ol_base_i & 24'hFF_FFFC;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        busy_o    = 1'b1;
        vram_rd_o = 1'b1;
        if (vram_ack_i) begin
          word_d  = vram_din_i;
          cnt_d   = cnt_q + CW'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        busy_o = 1'b1;
        if (cnt_q > MAX_CNT) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (!word_q[31]) begin
          // A strip with an empty mask carries no work; move straight on.
          if (word_q[30:25] == 6'd0) begin
            cur_d   = cur_q + 24'd4;
            state_d = S_FETCH;
          end else begin
            paddr_d = entry_addr;
            rem_d   = 4'd0;
            state_d = S_ISSUE;
          end
        end else begin
          unique case (word_q[30:29])
            2'b00, 2'b01: begin
              paddr_d  = entry_addr;
              rem_d    = word_q[28:25];
              stride_d = {stride_words[21:0], 2'b00};
              state_d  = S_ISSUE;
            end
            2'b11: begin
              if (word_q[28]) begin
                state_d = S_DONE;
              end else begin
                cur_d   = {word_q[23:2], 2'b00};
                state_d = S_FETCH;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_ISSUE: begin
        busy_o        = 1'b1;
        render_poly_o = 1'b1;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        busy_o = 1'b1;
        if (poly_drawn_i) begin
          if (rem_q != 4'd0) begin
            rem_d   = rem_q - 4'd1;
            paddr_d = paddr_q + stride_q;
            state_d = S_ISSUE;
          end else begin
            cur_d   = cur_q + 24'd4;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        list_done_o = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      pbase_q  <= '0;
      paddr_q  <= '0;
      stride_q <= '0;
      word_q   <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      pbase_q  <= pbase_d;
      paddr_q  <= paddr_d;
      stride_q <= stride_d;
      word_q   <= word_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

endmodule
